mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter slice.
//   state_t  : arbiter FSM states (IDLE / BUSY / RESP)
//   owner_t  : which requester owns the in-flight transaction
//   ERR_DATA : response data returned on a timeout (all ones; slice to DW)
//   TO_CNT_W : width of the BUSY-cycle timeout counter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [63:0] ERR_DATA = '1;
  localparam int          TO_CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of all requester-side and external-bus signals of mem_bus_arbiter.
//   slave  : the arbiter's view (takes requests + ext_rdata/ext_ready,
//            drives grants, responses and the external bus)
//   master : the environment's view (requesters + external memory)
interface mem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  // instruction-fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  // data requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  // shared response
  logic [DW-1:0] rdata;
  logic          err;
  // external bus
  logic          ext_valid;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;
  logic          ext_ready;
  // status
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ext_rdata, ext_ready,
    output if_gnt, if_rvalid, d_gnt, d_rvalid, rdata, err,
           ext_valid, ext_we, ext_addr, ext_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ext_rdata, ext_ready,
    input  if_gnt, if_rvalid, d_gnt, d_rvalid, rdata, err,
           ext_valid, ext_we, ext_addr, ext_wdata, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  : request vector, bit index = owner_t encoding (0 = fetch, 1 = data)
//   last : requester served most recently
//   en   : when low, no grant is issued
//   gnt  : one-hot grant (or zero)
// On a tie the requester that was not served last wins; a lone request wins.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last == OWN_D) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one external
// memory bus, one transaction at a time.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   bus      : mem_bus_arbiter_if.slave -- requester handshakes, shared
//              response (rdata/err), external bus and the busy flag
// Flow: IDLE grants combinationally and latches the request, BUSY drives the
// external bus until ext_ready or timeout, RESP pulses the owner's rvalid.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_arbiter_if.slave     bus
);

  // Counter value seen in the last allowed BUSY cycle; the count reaches
  // TIMEOUT on the edge that leaves BUSY.
  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state_reg;
  owner_t              owner_reg;
  owner_t              last_reg;
  logic [AW-1:0]       addr_reg;
  logic [DW-1:0]       wdata_reg;
  logic [DW-1:0]       rdata_reg;
  logic                ext_valid_reg;
  logic                ext_we_reg;
  logic                err_reg;
  logic                if_rvalid_reg;
  logic                d_rvalid_reg;
  logic                busy_reg;
  logic [TO_CNT_W-1:0] to_cnt_reg;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_en;
  logic       timeout_hit;

  assign req    = {bus.d_req, bus.if_req};
  // Grants only while idle and never during reset.
  assign arb_en = (state_reg == IDLE) && !rst;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_reg),
    .en   (arb_en),
    .gnt  (gnt)
  );

  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      last_reg      <= OWN_D;   // so fetch wins the first tie
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      ext_valid_reg <= 1'b0;
      ext_we_reg    <= 1'b0;
      err_reg       <= 1'b0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      to_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner_reg     <= gnt[1] ? OWN_D : OWN_IF;
            last_reg      <= gnt[1] ? OWN_D : OWN_IF;
            addr_reg      <= gnt[1] ? bus.d_addr : bus.if_addr;
            // Fetches are always reads with zero write data.
            wdata_reg     <= gnt[1] ? bus.d_wdata : '0;
            ext_we_reg    <= gnt[1] & bus.d_we;
            ext_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            to_cnt_reg    <= '0;
            state_reg     <= BUSY;
          end
        end

        BUSY: begin
          if (!bus.ext_ready) begin
            to_cnt_reg <= to_cnt_reg + TO_CNT_W'(1);
          end
          // ext_ready wins over a timeout landing in the same cycle.
          if (bus.ext_ready || timeout_hit) begin
            if (bus.ext_ready) begin
              rdata_reg <= ext_we_reg ? '0 : bus.ext_rdata;
              err_reg   <= 1'b0;
            end else begin
              rdata_reg <= ERR_DATA[DW-1:0];
              err_reg   <= 1'b1;
            end
            if_rvalid_reg <= (owner_reg == OWN_IF);
            d_rvalid_reg  <= (owner_reg == OWN_D);
            ext_valid_reg <= 1'b0;
            ext_we_reg    <= 1'b0;
            state_reg     <= RESP;
          end
        end

        RESP: begin
          if_rvalid_reg <= 1'b0;
          d_rvalid_reg  <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = gnt[0];
  assign bus.d_gnt     = gnt[1];
  assign bus.if_rvalid = if_rvalid_reg;
  assign bus.d_rvalid  = d_rvalid_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.err       = err_reg;
  assign bus.ext_valid = ext_valid_reg;
  assign bus.ext_we    = ext_we_reg;
  assign bus.ext_addr  = addr_reg;
  assign bus.ext_wdata = wdata_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model (transaction level) ----------------
  bit       m_active;   // a granted transaction is on the external bus
  bit       m_resp;     // its response is being reported this cycle
  int       m_age;      // BUSY cycles spent by the active transaction
  bit       m_own;      // 1 = data owner
  bit       m_last;     // 1 = data served last
  bit       m_we;
  bit       m_fresh;    // no response since reset: rdata/err must still be 0
  bit [7:0] m_addr;
  bit [7:0] m_wdata;
  bit [7:0] m_rdata;
  bit       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL t=%0t %s got=%0h exp=%0h", $time, name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_resp = 0; m_age = 0; m_own = 0; m_last = 1; m_we = 0;
    m_fresh = 1; m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0;
  endtask

  function automatic logic [1:0] exp_gnt();
    if (rst || m_active || m_resp) return 2'b00;
    if (bus.if_req && bus.d_req) return m_last ? 2'b01 : 2'b10;
    return {bus.d_req, bus.if_req};
  endfunction

  task automatic compare();
    logic [1:0] g;
    g = exp_gnt();
    chk("if_gnt",    bus.if_gnt,    g[0]);
    chk("d_gnt",     bus.d_gnt,     g[1]);
    chk("ext_valid", bus.ext_valid, m_active);
    chk("ext_we",    bus.ext_we,    m_active & m_we);
    chk("ext_addr",  bus.ext_addr,  m_addr);
    chk("ext_wdata", bus.ext_wdata, m_wdata);
    chk("busy",      bus.busy,      m_active | m_resp);
    chk("if_rvalid", bus.if_rvalid, m_resp & !m_own);
    chk("d_rvalid",  bus.d_rvalid,  m_resp & m_own);
    if (m_resp || m_fresh) begin
      chk("rdata", bus.rdata, m_rdata);
      chk("err",   bus.err,   m_err);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    logic [1:0] g;
    g = exp_gnt();
    if (rst) begin
      model_reset();
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_active) begin
      m_age++;
      if (bus.ext_ready) begin
        m_rdata = m_we ? 8'h00 : bus.ext_rdata;
        m_err   = 0;
        m_active = 0; m_resp = 1; m_fresh = 0;
      end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
        m_rdata = 8'hFF;
        m_err   = 1;
        m_active = 0; m_resp = 1; m_fresh = 0;
      end
    end else if (g != 2'b00) begin
      m_active = 1;
      m_age    = 0;
      m_own    = g[1];
      m_last   = g[1];
      m_addr   = g[1] ? bus.d_addr : bus.if_addr;
      m_we     = g[1] & bus.d_we;
      m_wdata  = g[1] ? bus.d_wdata : 8'h00;
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic settle();
    #1;
    compare();
  endtask

  task automatic finish_cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.ext_rdata = 0; bus.ext_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    bit  slow;

    rst = 1;
    set_idle();
    @(negedge clk);
    model_reset();

    // ---- reset state; requests while rst is high must not be granted ----
    bus.if_req = 1; bus.d_req = 1;
    settle();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_d_gnt",  bus.d_gnt, 0);
    chk("rst_ext_valid", bus.ext_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    finish_cycle();
    rst = 0;
    set_idle();
    settle(); finish_cycle();

    // ---- fetch read, minimum latency ----
    bus.if_req = 1; bus.if_addr = 8'h10;
    settle(); chk("fr_gnt", bus.if_gnt, 1); finish_cycle();
    set_idle(); bus.ext_ready = 1; bus.ext_rdata = 8'hA5;
    settle(); chk("fr_ext_valid", bus.ext_valid, 1); chk("fr_ext_addr", bus.ext_addr, 8'h10);
    finish_cycle();
    set_idle();
    settle(); chk("fr_rvalid", bus.if_rvalid, 1); chk("fr_rdata", bus.rdata, 8'hA5);
    chk("fr_err", bus.err, 0);
    finish_cycle();

    // ---- data write with ext_ready delayed 3 cycles ----
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h3C; bus.d_wdata = 8'h5A;
    settle(); chk("wr_gnt", bus.d_gnt, 1); finish_cycle();
    set_idle(); bus.d_req = 1; bus.d_wdata = 8'h11;   // changes after grant are ignored
    for (int i = 0; i < 3; i++) begin
      settle(); chk("wr_ext_we", bus.ext_we, 1); chk("wr_ext_wdata", bus.ext_wdata, 8'h5A);
      finish_cycle();
      bus.d_req = 0;
    end
    bus.ext_ready = 1; bus.ext_rdata = 8'h77;
    settle(); finish_cycle();
    set_idle();
    settle(); chk("wr_rvalid", bus.d_rvalid, 1); chk("wr_rdata", bus.rdata, 8'h00);
    finish_cycle();

    // ---- contention: both held for 4 transactions -> IF, D, IF, D ----
    for (int k = 0; k < 4; k++) begin
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 0;
      bus.if_addr = 8'(8'h20 + k); bus.d_addr = 8'(8'h40 + k);
      bus.ext_ready = 1; bus.ext_rdata = 8'(8'hC0 + k);
      settle();
      chk("ct_if_gnt", bus.if_gnt, (k % 2) == 0);
      chk("ct_d_gnt",  bus.d_gnt,  (k % 2) == 1);
      finish_cycle();
      settle(); finish_cycle();                      // BUSY, completes
      settle(); chk("ct_rvalid", bus.if_rvalid | bus.d_rvalid, 1); finish_cycle();
    end
    set_idle();
    settle(); finish_cycle();

    // ---- timeout, then the same with ext_ready on the final cycle ----
    for (int pass = 0; pass < 2; pass++) begin
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h44;
      settle(); chk("to_gnt", bus.d_gnt, 1); finish_cycle();
      set_idle();
      n = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        bus.ext_ready = (pass == 1) && (n == TIMEOUT - 1);
        bus.ext_rdata = 8'h3E;
        settle();
        if (bus.d_rvalid) begin
          seen = 1;
          chk("to_busy_cycles", n, TIMEOUT);
          chk("to_err", bus.err, (pass == 0) ? 1 : 0);
          chk("to_rdata", bus.rdata, (pass == 0) ? 8'hFF : 8'h3E);
        end else if (bus.ext_valid) begin
          n++;
        end
        finish_cycle();
        bus.ext_ready = 0;
      end
      if (!seen) chk("to_no_rvalid", 0, 1);
      set_idle();
      settle(); finish_cycle();
    end

    // ---- reset in the second BUSY cycle ----
    bus.d_req = 1; bus.d_addr = 8'h99; bus.d_wdata = 8'h66; bus.d_we = 1;
    settle(); chk("rm_gnt", bus.d_gnt, 1); finish_cycle();
    set_idle();
    settle(); finish_cycle();                       // BUSY 1
    rst = 1;
    settle(); chk("rm_busy2_valid", bus.ext_valid, 1); finish_cycle();  // BUSY 2
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rm_ext_valid", bus.ext_valid, 0);
      chk("rm_rvalid", bus.d_rvalid | bus.if_rvalid, 0);
      chk("rm_ext_addr", bus.ext_addr, 0);
      chk("rm_ext_wdata", bus.ext_wdata, 0);
      chk("rm_busy", bus.busy, 0);
      finish_cycle();
    end
    bus.if_req = 1; bus.d_req = 1;
    settle(); chk("rm_tie_if", bus.if_gnt, 1); chk("rm_tie_d", bus.d_gnt, 0); finish_cycle();
    set_idle();

    // ---- randomized traffic ----
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) slow = ~slow;
      rst           = ($urandom_range(0, 299) == 0);
      bus.if_req    = ($urandom_range(0, 2) != 0);
      bus.d_req     = ($urandom_range(0, 2) != 0);
      bus.d_we      = $urandom_range(0, 1);
      bus.if_addr   = 8'($urandom);
      bus.d_addr    = 8'($urandom);
      bus.d_wdata   = 8'($urandom);
      bus.ext_rdata = 8'($urandom);
      bus.ext_ready = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
      settle();
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
